gin_mcast_router: RTL and testbench

Receiving end of one global input network (GIN) stream: accepts valid/ready beats carrying data plus an (X, Y) tag from the pass controller and multicasts each beat to every PE whose scan-loaded X-ID and Y-ID match the tag. One instance is used per stream (ifmap, filter, ipsum). It also owns that stream's X-ID and Y-ID scan chains, which the controller loads during its configuration phase.

---
 rtl/gin_mcast_router.sv | 132 +++++++++++++
 tb/tb_gin_mcast_router.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/gin_mcast_router.sv
// gin_mcast_router: GIN receive side; multicasts each tagged beat to the PEs
// whose scan-loaded X-ID/Y-ID match the beat's (X, Y) tag.
// Ports:
//   clk, rst (async, active-high)
//   set_XID/XID_scan_in, set_YID/YID_scan_in : ID scan chains
//   in_valid/in_ready/in_data/tag_X/tag_Y    : controller beat input
//   pe_valid[N]/pe_ready[N]/pe_data          : per-PE delivery
//   drop_cnt                                 : saturating count of unmatched beats
// Optional: define GIN_TAG_WILDCARD_EN so an all-ones tag matches every ID.
module gin_mcast_router #(
  parameter int NUMS_PE_ROW = 6,
  parameter int NUMS_PE_COL = 8,
  parameter int XID_BITS    = 4,
  parameter int YID_BITS    = 3,
  parameter int DATA_SIZE   = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             set_XID,
  input  logic [XID_BITS-1:0]              XID_scan_in,
  input  logic                             set_YID,
  input  logic [YID_BITS-1:0]              YID_scan_in,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_SIZE-1:0]             in_data,
  input  logic [XID_BITS-1:0]              tag_X,
  input  logic [YID_BITS-1:0]              tag_Y,
  output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0] pe_valid,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0] pe_ready,
  output logic [DATA_SIZE-1:0]             pe_data,
  output logic [15:0]                      drop_cnt
);

  localparam int N = NUMS_PE_ROW * NUMS_PE_COL;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_nxt;

  logic [XID_BITS-1:0] xid [N];
  logic [YID_BITS-1:0] yid [NUMS_PE_ROW];

  logic [N-1:0] pending, pending_nxt;
  logic [N-1:0] match;
  logic [N-1:0] done;
  logic         accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) xid[k] <= '0;
    end else if (set_XID) begin
      for (int k = 0; k < N-1; k++) xid[k] <= xid[k+1];
      xid[N-1] <= XID_scan_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUMS_PE_ROW; r++) yid[r] <= '0;
    end else if (set_YID) begin
      for (int r = 0; r < NUMS_PE_ROW-1; r++) yid[r] <= yid[r+1];
      yid[NUMS_PE_ROW-1] <= YID_scan_in;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_match
    localparam int ROW = i / NUMS_PE_COL;
    logic x_hit, y_hit;
`ifdef GIN_TAG_WILDCARD_EN
    assign x_hit = (xid[i] == tag_X) || (&tag_X);
    assign y_hit = (yid[ROW] == tag_Y) || (&tag_Y);
`else
    assign x_hit = (xid[i] == tag_X);
    assign y_hit = (yid[ROW] == tag_Y);
`endif
    assign match[i] = x_hit & y_hit;
  end

  // rst gates in_ready directly so no beat is taken while reset is held.
  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign pe_valid = {N{state == BUSY}} & pending;
  assign done     = pe_valid & pe_ready;

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    case (state)
      IDLE: begin
        if (accept) begin
          pending_nxt = match;
          if (|match) state_nxt = BUSY;
        end
      end
      BUSY: begin
        pending_nxt = pending & ~done;
        if (pending_nxt == '0) state_nxt = IDLE;
      end
      default: begin
        state_nxt   = IDLE;
        pending_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pe_data <= '0;
    end else if (accept) begin
      pe_data <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (accept && (match == '0) && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_gin_mcast_router.sv
// tb_gin_mcast_router: table vectors plus hand sequences for gin_mcast_router.
// Expected beats go through a queue scoreboard popped at delivery.
module tb_gin_mcast_router;

  localparam int N = 48;

  logic        clk = 1'b0;
  logic        rst;
  logic        set_XID;
  logic [3:0]  XID_scan_in;
  logic        set_YID;
  logic [2:0]  YID_scan_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  tag_X;
  logic [2:0]  tag_Y;
  logic [N-1:0] pe_valid;
  logic [N-1:0] pe_ready;
  logic [31:0] pe_data;
  logic [15:0] drop_cnt;

  gin_mcast_router dut (
    .clk(clk), .rst(rst),
    .set_XID(set_XID), .XID_scan_in(XID_scan_in),
    .set_YID(set_YID), .YID_scan_in(YID_scan_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .tag_X(tag_X), .tag_Y(tag_Y),
    .pe_valid(pe_valid), .pe_ready(pe_ready),
    .pe_data(pe_data), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   tx;
    logic [2:0]   ty;
    logic [31:0]  d;
    logic [N-1:0] m;
  } vec_t;

  typedef struct {
    logic [N-1:0] m;
    logic [31:0]  d;
  } exp_t;

  vec_t  tbl [7];
  exp_t  sb [$];
  int    n_cmp = 0;
  int    n_err = 0;
  logic [15:0] exp_drop = 16'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bump_drop();
    if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
  endtask

  // One-beat send; the router's latency is exactly one cycle so the
  // scoreboard entry is popped right after the accept edge.
  task automatic send(input logic [3:0] x, input logic [2:0] y,
                      input logic [31:0] d, input logic [N-1:0] m);
    exp_t e;
    chk("in_ready_before_send", 64'(in_ready), 64'd1);
    tag_X = x; tag_Y = y; in_data = d; in_valid = 1'b1;
    e.m = m; e.d = d;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
    e = sb.pop_front();
    if (e.m == '0) begin
      bump_drop();
      chk("drop_pe_valid", 64'(pe_valid), 64'd0);
      chk("drop_in_ready", 64'(in_ready), 64'd1);
      chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    end else begin
      chk("deliver_pe_valid", 64'(pe_valid), 64'(e.m));
      chk("deliver_pe_data", 64'(pe_data), 64'(e.d));
      chk("busy_in_ready", 64'(in_ready), 64'd0);
    end
  endtask

  task automatic release_all();
    pe_ready = '1;
    tick();
    pe_ready = '0;
    chk("done_pe_valid", 64'(pe_valid), 64'd0);
    chk("done_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic scan_x_mod();
    for (int k = 0; k < N; k++) begin
      XID_scan_in = 4'(k % 16);
      set_XID = 1'b1;
      tick();
    end
    set_XID = 1'b0;
  endtask

  task automatic scan_x_const(input logic [3:0] v);
    for (int k = 0; k < N; k++) begin
      XID_scan_in = v;
      set_XID = 1'b1;
      tick();
    end
    set_XID = 1'b0;
  endtask

  task automatic scan_y();
    for (int r = 0; r < 6; r++) begin
      YID_scan_in = 3'(r);
      set_YID = 1'b1;
      tick();
    end
    set_YID = 1'b0;
  endtask

  initial begin
    logic [N-1:0] rem;
    logic [N-1:0] row1;

    rst = 1'b1;
    set_XID = 1'b0; XID_scan_in = '0;
    set_YID = 1'b0; YID_scan_in = '0;
    in_valid = 1'b0; in_data = '0;
    tag_X = '0; tag_Y = '0; pe_ready = '0;

    // xid[k] = k mod 16, yid[r] = r after the scan load.
    tbl[0] = '{tx: 4'd3,  ty: 3'd0, d: 32'hA5A5_0001, m: N'(1) << 3};
    tbl[1] = '{tx: 4'd10, ty: 3'd1, d: 32'h1111_2222, m: N'(1) << 10};
    tbl[2] = '{tx: 4'd0,  ty: 3'd2, d: 32'hDEAD_BEEF, m: N'(1) << 16};
    tbl[3] = '{tx: 4'd14, ty: 3'd5, d: 32'h0BAD_F00D, m: N'(1) << 46};
    tbl[4] = '{tx: 4'd3,  ty: 3'd6, d: 32'h0000_0006, m: '0};
    tbl[5] = '{tx: 4'd7,  ty: 3'd3, d: 32'h0000_0007, m: '0};
    tbl[6] = '{tx: 4'd5,  ty: 3'd4, d: 32'h5555_AAAA, m: N'(1) << 37};

    repeat (2) tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_pe_valid", 64'(pe_valid), 64'd0);
    chk("rst_pe_data", 64'(pe_data), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    scan_x_mod();
    scan_y();

    for (int v = 0; v < 7; v++) begin
      send(tbl[v].tx, tbl[v].ty, tbl[v].d, tbl[v].m);
      if (tbl[v].m != '0) release_all();
    end

    // Reset while a unicast beat is outstanding.
    send(4'd3, 3'd0, 32'hCAFE_0003, N'(1) << 3);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_pe_valid", 64'(pe_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    tick();
    rst = 1'b0;
    exp_drop = 16'd0;
    #1;
    chk("midrst_rel_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("midrst_drop_cnt", 64'(drop_cnt), 64'(exp_drop));

    // Multicast to row 1 with staggered readies and a rescan in flight.
    scan_x_const(4'd2);
    scan_y();
    row1 = N'(8'hFF) << 8;
    send(4'd2, 3'd1, 32'h7777_0001, row1);
    rem = row1;
    for (int p = 8; p < 16; p++) begin
      pe_ready = N'(1) << p;
      if (p == 8) begin
        XID_scan_in = 4'd0;
        set_XID = 1'b1;
      end
      tick();
      set_XID = 1'b0;
      rem[p] = 1'b0;
      chk("stagger_pe_valid", 64'(pe_valid), 64'(rem));
      chk("stagger_in_ready", 64'(in_ready), (p == 15) ? 64'd1 : 64'd0);
      if (p != 15) chk("stagger_pe_data", 64'(pe_data), 64'h7777_0001);
    end
    pe_ready = '0;

    send(4'd9, 3'd5, 32'h0000_0009, '0);

`ifdef GIN_TAG_WILDCARD_EN
    send(4'hF, 3'd1, 32'h0000_00F1, row1);
    release_all();
`else
    send(4'hF, 3'd1, 32'h0000_00F1, '0);
`endif

    tag_X = 4'd9; tag_Y = 3'd5; in_valid = 1'b1;
    repeat (70000) tick();
    in_valid = 1'b0;
    chk("sat_drop_cnt", 64'(drop_cnt), 64'hFFFF);
    chk("sat_pe_valid", 64'(pe_valid), 64'd0);
    tick();
    chk("sat_in_ready", 64'(in_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
